vga_timing_sched: RTL and testbench
===================================

Name: vga_timing_sched

Overview:
Central timing controller for the VGA pixel datapath. Generates hsync/vsync, the display-enable window and beam position, plus line/frame start strobes and a frame counter that schedules per-frame animation updates of the pattern generator. Sits between the top-level wrapper pins and the combinational pixel/colour logic, and is the single owner of raster sequencing.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  pixel-domain clock
rst  in  1  synchronous reset, active-high
pix_en  in  1  pixel tick; counters advance only when 1
hsync  out  1  horizontal sync, level per SYNC_ACTIVE
vsync  out  1  vertical sync, level per SYNC_ACTIVE
display_on  out  1  high inside the 640x480 visible window
hpos  out  10  current column 0..H_TOTAL-1
vpos  out  10  current line 0..V_TOTAL-1
line_start  out  1  one-cycle pulse when hpos becomes 0
frame_start  out  1  one-cycle pulse when hpos=0 and vpos=0
frame_count  out  8  completed-frame counter, wraps 255->0

Behaviour:
- One clock (clk), synchronous active-high reset (rst); no other reset.
- H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
- Reset values: hpos=0, vpos=0, hsync=vsync=!SYNC_ACTIVE, display_on=0, line_start=0, frame_start=0, frame_count=0.
- All outputs are registered; they describe the counter state one clk after it is reached. First pix_en after reset release: outputs show (0,0), display_on=1, line_start=1, frame_start=1.
- pix_en=0: counters and all level outputs hold; line_start/frame_start forced 0.
- Horizontal: hpos increments per pix_en; at H_TOTAL-1 wraps to 0 and vpos advances.
- Vertical: vpos wraps V_TOTAL-1 -> 0 coincident with hpos wrap.
- hsync asserted for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751].
- vsync asserted for vpos in [V_DISPLAY+V_FRONT, +V_SYNC-1] = [490,491], for full lines.
- display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
- frame_count increments on the pix_en that wraps (799,524)->(0,0); same cycle as frame_start output rises.
- Reset asserted mid-frame: next cycle all outputs at reset values; raster restarts at (0,0), frame_count cleared.
- Derived line/frame periods with pix_en tied high: 800 clk, 420000 clk.

Optional Feature:
VGA_PAUSE_EN: adds input port pause (1 bit). When defined and pause=1, frame_count holds at frame wrap (animation freeze) while raster/sync continue unaffected; pause sampled only on the wrap cycle. When undefined, port absent and frame_count always increments.

Decomposition:
- Package vga_timing_pkg: default timing constants (H_*/V_* as listed), H_TOTAL/V_TOTAL, position width (10), frame counter width (8).
- Sub-module vga_axis_counter: parameterised wrap counter with enable, returning count and wrap flag plus sync/active window decode; instantiated once for horizontal (enable=pix_en) and once for vertical (enable=pix_en && h_wrap).

Test Plan:
- Reset 5 cycles, pix_en=1 -> cycle after release: hpos=0, vpos=0, frame_start=1, line_start=1, display_on=1, hsync=vsync=1.
- Free-run one line -> hsync falls at hpos=656, low exactly 96 clk, hsync falling edges 800 clk apart; display_on low for hpos 640..799.
- Free-run 2 frames -> vsync low exactly 1600 clk (lines 490-491), falling edges 420000 clk apart; frame_count 0->1->2.
- pix_en toggling 1,0,1,0 -> hpos advances once per two clk; line period 1600 clk; no strobe while pix_en=0.
- Assert rst at (300,200) for 1 cycle -> next cycle all outputs at reset values; raster resumes from (0,0), frame_count=0.
- With VGA_PAUSE_EN, pause=1 across frame wrap -> frame_count unchanged, frame_start still pulses, sync timing identical; pause=0 -> increments at next wrap.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants shared by the VGA timing scheduler.
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int POS_W   = 10;
  localparam int FRAME_W = 8;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with enable, plus sync-window and active-window decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL,
  parameter int SYNC_START = H_DISPLAY + H_FRONT,
  parameter int SYNC_END   = H_DISPLAY + H_FRONT + H_SYNC - 1,
  parameter int ACTIVE     = H_DISPLAY,
  parameter int W          = POS_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output logic         sync_o,
  output logic         active_o
);

  localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_S = W'(SYNC_START);
  localparam logic [W-1:0] SYNC_E = W'(SYNC_END);
  localparam logic [W-1:0] ACT_N  = W'(ACTIVE);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Sync/active are raw (active-high) window decodes; polarity is applied by the top.
  assign count_o  = count_q;
  assign wrap_o   = en_i && (count_q == LAST);
  assign sync_o   = (count_q >= SYNC_S) && (count_q <= SYNC_E);
  assign active_o = count_q < ACT_N;

endmodule

// File: rtl/vga_timing_sched.sv
// VGA raster timing scheduler: registered sync/enable/position/strobes and frame counter.
// Optional macro VGA_PAUSE_EN adds pause_i, which freezes frame_count at frame wrap.
module vga_timing_sched
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY_P = H_DISPLAY,
  parameter int   H_FRONT_P   = H_FRONT,
  parameter int   H_SYNC_P    = H_SYNC,
  parameter int   H_BACK_P    = H_BACK,
  parameter int   V_DISPLAY_P = V_DISPLAY,
  parameter int   V_FRONT_P   = V_FRONT,
  parameter int   V_SYNC_P    = V_SYNC,
  parameter int   V_BACK_P    = V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en_i,
`ifdef VGA_PAUSE_EN
  input  logic               pause_i,
`endif
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               display_on_o,
  output logic [POS_W-1:0]   hpos_o,
  output logic [POS_W-1:0]   vpos_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic [FRAME_W-1:0] frame_count_o
);

  localparam int HT = H_DISPLAY_P + H_FRONT_P + H_SYNC_P + H_BACK_P;
  localparam int VT = V_DISPLAY_P + V_FRONT_P + V_SYNC_P + V_BACK_P;

  logic [POS_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;

  vga_axis_counter #(
    .TOTAL(HT), .SYNC_START(H_DISPLAY_P + H_FRONT_P),
    .SYNC_END(H_DISPLAY_P + H_FRONT_P + H_SYNC_P - 1), .ACTIVE(H_DISPLAY_P), .W(POS_W)
  ) u_h (
    .clk(clk), .rst(rst), .en_i(pix_en_i),
    .count_o(h_cnt), .wrap_o(h_wrap), .sync_o(h_sync), .active_o(h_act)
  );

  vga_axis_counter #(
    .TOTAL(VT), .SYNC_START(V_DISPLAY_P + V_FRONT_P),
    .SYNC_END(V_DISPLAY_P + V_FRONT_P + V_SYNC_P - 1), .ACTIVE(V_DISPLAY_P), .W(POS_W)
  ) u_v (
    .clk(clk), .rst(rst), .en_i(h_wrap),
    .count_o(v_cnt), .wrap_o(v_wrap), .sync_o(v_sync), .active_o(v_act)
  );

  // Internal frame tally advances with the raster wrap; the registered output picks it
  // up one pixel later, together with the frame_start strobe for (0,0).
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               frame_inc;

`ifdef VGA_PAUSE_EN
  assign frame_inc = v_wrap && !pause_i;
`else
  assign frame_inc = v_wrap;
`endif

  logic [POS_W-1:0]   hpos_q, hpos_d, vpos_q, vpos_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, disp_q, disp_d;
  logic               line_q, line_d, frame_q, frame_d;
  logic [FRAME_W-1:0] fcount_q, fcount_d;

  always_comb begin
    frame_cnt_d = frame_inc ? frame_cnt_q + 1'b1 : frame_cnt_q;
    hpos_d   = hpos_q;
    vpos_d   = vpos_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    disp_d   = disp_q;
    fcount_d = fcount_q;
    line_d   = 1'b0;
    frame_d  = 1'b0;
    if (pix_en_i) begin
      hpos_d   = h_cnt;
      vpos_d   = v_cnt;
      hsync_d  = h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d  = v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      disp_d   = h_act && v_act;
      fcount_d = frame_cnt_q;
      line_d   = (h_cnt == '0);
      frame_d  = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      hpos_q      <= '0;
      vpos_q      <= '0;
      hsync_q     <= ~SYNC_ACTIVE;
      vsync_q     <= ~SYNC_ACTIVE;
      disp_q      <= 1'b0;
      fcount_q    <= '0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      disp_q      <= disp_d;
      fcount_q    <= fcount_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
    end
  end

  assign hpos_o        = hpos_q;
  assign vpos_o        = vpos_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign display_on_o  = disp_q;
  assign line_start_o  = line_q;
  assign frame_start_o = frame_q;
  assign frame_count_o = fcount_q;

endmodule

// File: tb/tb_vga_timing_sched.sv
// Self-checking bench for vga_timing_sched: full horizontal timing, shortened vertical
// timing (12 lines) so multi-frame behaviour fits a short run. Honours VGA_PAUSE_EN.
module tb_vga_timing_sched;

  localparam int HT = 800;
  localparam int VD = 6;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VT = VD + VF + VS + VB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       pixEn = 1'b1;
  logic       pauseVal = 1'b0;
  logic       hsync, vsync, displayOn, lineStart, frameStart;
  logic [9:0] hpos, vpos;
  logic [7:0] frameCount;

  vga_timing_sched #(
    .H_DISPLAY_P(640), .H_FRONT_P(16), .H_SYNC_P(96), .H_BACK_P(48),
    .V_DISPLAY_P(VD), .V_FRONT_P(VF), .V_SYNC_P(VS), .V_BACK_P(VB), .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .pix_en_i(pixEn),
`ifdef VGA_PAUSE_EN
    .pause_i(pauseVal),
`endif
    .hsync_o(hsync), .vsync_o(vsync), .display_on_o(displayOn),
    .hpos_o(hpos), .vpos_o(vpos), .line_start_o(lineStart),
    .frame_start_o(frameStart), .frame_count_o(frameCount)
  );

  typedef struct packed {
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } outs_t;

  typedef struct {
    logic  r;
    logic  p;
    outs_t exp;
  } vec_t;

  outs_t expQ[$];
  outs_t mOut, lastGot;
  int    compared = 0;
  int    mismatched = 0;
  int    mh = 0, mv = 0, mfc = 0;
  int    cyc = 0;
  logic  prevH = 1'b1, prevV = 1'b1;
  int    hFallCyc = 0, hFallPos = -1, hPeriod = 0, hLowLen = 0;
  int    vFallCyc = 0, vPeriod = 0, vLowLen = 0;
  int    strobeIdle = 0;

  function automatic outs_t mkOut(int h, int v, logic hs, logic vs, logic de,
                                  logic ls, logic fs, int fc);
    outs_t o;
    o.hpos = 10'(h);
    o.vpos = 10'(v);
    o.hs = hs;
    o.vs = vs;
    o.de = de;
    o.ls = ls;
    o.fs = fs;
    o.fc = 8'(fc);
    return o;
  endfunction

  // Reference raster: (mh,mv) is the position the next enabled pixel will report.
  task automatic modelStep(input logic r, input logic p, input logic pz);
    if (r) begin
      mOut = mkOut(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      mh = 0;
      mv = 0;
      mfc = 0;
    end else if (p) begin
      mOut = mkOut(mh, mv, !(mh >= 656 && mh <= 751), !(mv >= VD + VF && mv < VD + VF + VS),
                   (mh < 640) && (mv < VD), mh == 0, (mh == 0) && (mv == 0), mfc);
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) begin
          mv = 0;
`ifdef VGA_PAUSE_EN
          if (!pz) mfc = (mfc + 1) % 256;
`else
          if (pz || !pz) mfc = (mfc + 1) % 256;
`endif
        end
      end
    end else begin
      mOut.ls = 1'b0;
      mOut.fs = 1'b0;
    end
  endtask

  task automatic showMismatch(input string name, input outs_t got, input outs_t want);
    $display("[TB] FAIL %s cyc=%0d got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
             name, cyc, got.hpos, got.vpos, got.hs, got.vs, got.de, got.ls, got.fs, got.fc,
             want.hpos, want.vpos, want.hs, want.vs, want.de, want.ls, want.fs, want.fc);
  endtask

  task automatic checkOutput(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL %s got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic checkVector(input string name, input outs_t want);
    compared++;
    if (lastGot !== want) begin
      mismatched++;
      showMismatch(name, lastGot, want);
    end
  endtask

  // One clock: drive inputs, queue the model's expectation, sample #1 after the edge.
  task automatic applyStimulus(input logic r, input logic p);
    outs_t want;
    rst = r;
    pixEn = p;
    modelStep(r, p, pauseVal);
    expQ.push_back(mOut);
    @(posedge clk);
    #1;
    cyc++;
    lastGot = {hpos, vpos, hsync, vsync, displayOn, lineStart, frameStart, frameCount};
    want = expQ.pop_front();
    compared++;
    if (lastGot !== want) begin
      mismatched++;
      showMismatch("scoreboard", lastGot, want);
    end
    if (!p && (lastGot.ls || lastGot.fs)) strobeIdle++;
    if (prevH && !lastGot.hs) begin
      hPeriod = cyc - hFallCyc;
      hFallCyc = cyc;
      hFallPos = int'(lastGot.hpos);
    end
    if (!prevH && lastGot.hs) hLowLen = cyc - hFallCyc;
    if (prevV && !lastGot.vs) begin
      vPeriod = cyc - vFallCyc;
      vFallCyc = cyc;
    end
    if (!prevV && lastGot.vs) vLowLen = cyc - vFallCyc;
    prevH = lastGot.hs;
    prevV = lastGot.vs;
  endtask

  initial begin
    vec_t vecs[9];
    int   n;
    int   seen1;
    int   fsAtInc;
    int   preFc;
    int   fcBefore;
    int   sawFs;

    for (int i = 0; i < 5; i++) vecs[i] = '{r: 1'b1, p: 1'b1, exp: mkOut(0, 0, 1, 1, 0, 0, 0, 0)};
    vecs[5] = '{r: 1'b0, p: 1'b1, exp: mkOut(0, 0, 1, 1, 1, 1, 1, 0)};
    vecs[6] = '{r: 1'b0, p: 1'b1, exp: mkOut(1, 0, 1, 1, 1, 0, 0, 0)};
    vecs[7] = '{r: 1'b0, p: 1'b0, exp: mkOut(1, 0, 1, 1, 1, 0, 0, 0)};
    vecs[8] = '{r: 1'b0, p: 1'b1, exp: mkOut(2, 0, 1, 1, 1, 0, 0, 0)};

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].r, vecs[i].p);
      checkVector($sformatf("vector%0d", i), vecs[i].exp);
    end

    repeat (1700) applyStimulus(1'b0, 1'b1);
    checkOutput("hsyncFallPos", hFallPos, 656);
    checkOutput("hsyncLowLen", hLowLen, 96);
    checkOutput("hsyncPeriod", hPeriod, 800);

    n = 0;
    seen1 = 0;
    fsAtInc = 0;
    while (lastGot.fc != 8'd2 && n < 3 * VT * HT) begin
      applyStimulus(1'b0, 1'b1);
      if (lastGot.fc == 8'd1) seen1 = 1;
      if (lastGot.fc == 8'd2) fsAtInc = int'(lastGot.fs);
      n++;
    end
    checkOutput("frameCountReached2", int'(lastGot.fc), 2);
    checkOutput("frameCountSaw1", seen1, 1);
    checkOutput("frameStartWithInc", fsAtInc, 1);
    checkOutput("vsyncLowLen", vLowLen, VS * HT);
    checkOutput("vsyncPeriod", vPeriod, VT * HT);

    strobeIdle = 0;
    repeat (2500) begin
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("toggleLinePeriod", hPeriod, 2 * HT);
    checkOutput("toggleHsyncLow", hLowLen, 2 * 96);
    checkOutput("noStrobeWhileIdle", strobeIdle, 0);

    n = 0;
    while (!(mh == 300 && mv == 5) && n < 2 * VT * HT) begin
      applyStimulus(1'b0, 1'b1);
      n++;
    end
    checkOutput("reachMidFrame", (mh == 300 && mv == 5) ? 1 : 0, 1);
    preFc = int'(lastGot.fc);
    checkOutput("preResetFcNonzero", (preFc != 0) ? 1 : 0, 1);
    applyStimulus(1'b1, 1'b1);
    checkVector("midResetValues", mkOut(0, 0, 1, 1, 0, 0, 0, 0));
    applyStimulus(1'b0, 1'b1);
    checkVector("restartOrigin", mkOut(0, 0, 1, 1, 1, 1, 1, 0));

`ifdef VGA_PAUSE_EN
    fcBefore = int'(lastGot.fc);
    pauseVal = 1'b1;
    sawFs = 0;
    n = 0;
    while (sawFs == 0 && n < 2 * VT * HT) begin
      applyStimulus(1'b0, 1'b1);
      if (lastGot.fs) sawFs = 1;
      n++;
    end
    checkOutput("pauseFrameStart", sawFs, 1);
    checkOutput("pauseHoldsCount", int'(lastGot.fc), fcBefore);
    pauseVal = 1'b0;
    sawFs = 0;
    n = 0;
    while (sawFs == 0 && n < 2 * VT * HT) begin
      applyStimulus(1'b0, 1'b1);
      if (lastGot.fs) sawFs = 1;
      n++;
    end
    checkOutput("unpauseFrameStart", sawFs, 1);
    checkOutput("unpauseIncrements", int'(lastGot.fc), (fcBefore + 1) % 256);
`else
    fcBefore = 0;
    sawFs = 0;
    if (fcBefore != sawFs) $display("[TB] pause feature not built");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
